ff_bist_ctrl: RTL and testbench

Built-in self-test controller that drives the data input of a D flip-flop under test with a pseudo-random bit stream. It samples the flip-flop's true and complementary outputs and checks them against a delayed model of its own stimulus. It replaces a hand-written stimulus bench with an on-chip driver and checker, so flip-flop cells can be qualified in hardware. It sits beside the flip-flop under test on the same clock.

---
 rtl/ff_bist_ctrl_pkg.sv | 21 ++
 rtl/bist_lfsr8.sv | 31 +++
 rtl/ff_bist_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ff_bist_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ff_bist_ctrl_pkg.sv
// Shared definitions for the flip-flop BIST controller: FSM states, LFSR taps and constants.
// The LFSR step function is kept here so other cell BIST blocks can reuse it.
package ff_bist_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   // Right-shifting Fibonacci form of x^8+x^6+x^5+x^4+1: feedback from bits 0,2,3,4
   localparam logic [7:0] LFSR_TAPS    = 8'h1D;
   localparam logic [7:0] DEFAULT_SEED = 8'hA5;
   localparam logic [7:0] NO_ERR_IDX   = 8'hFF;

   function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
      return {^(s & LFSR_TAPS), s[7:1]};
   endfunction

endpackage

// File: rtl/bist_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable.
// Reusable stimulus source for cell-level BIST controllers.
module bist_lfsr8
   import ff_bist_ctrl_pkg::*;
#(
   parameter logic [7:0] RST_VAL = DEFAULT_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] seed,
   output logic [7:0] state
);

   logic [7:0] state_r;

   // State register: load has priority over advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RST_VAL;
      end else if (load) begin
         state_r <= seed;
      end else if (en) begin
         state_r <= lfsr8_step(state_r);
      end
   end

   assign state = state_r;

endmodule

// File: rtl/ff_bist_ctrl.sv
// BIST controller for a D flip-flop cell: drives a pseudo-random stream on a_drv and checks
// b_obs/c_obs against a delayed copy of that stream, reporting error count and first failing vector.
module ff_bist_ctrl
   import ff_bist_ctrl_pkg::*;
#(
   parameter int unsigned N_VECTORS = 16,
   parameter int unsigned DUT_LAT   = 1,
   parameter int unsigned ERR_W     = 8,
   parameter logic [7:0]  SEED      = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_drv,
   input  logic             b_obs,
   input  logic             c_obs,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       first_err_idx
);

   // An all-zero seed would lock the LFSR
   localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0]       LAST_IDX = 8'(N_VECTORS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   bist_state_e        state_r;
   bist_state_e        state_nxt_s;
   logic [7:0]         lfsr_s;
   logic               lfsr_unused_s;
   logic               a_drv_r;
   logic               busy_r;
   logic               done_r;
   logic               pass_r;
   logic [ERR_W-1:0]   err_count_r;
   logic [ERR_W-1:0]   err_nxt_s;
   logic [7:0]         first_err_r;
   logic [7:0]         drv_idx_r;
   logic [7:0]         chk_idx_r;
   logic [DUT_LAT-1:0] dly_r;
   logic [DUT_LAT-1:0] vld_r;
   logic               load_s;
   logic               adv_s;
   logic               chk_s;
   logic               fin_s;
   logic               fail_s;

   bist_lfsr8 #(
      .RST_VAL (SEED_EFF)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s),
      .en    (adv_s),
      .seed  (SEED_EFF),
      .state (lfsr_s)
   );

   // After a right shift the new LSB is the current bit 1, so only that bit feeds a_drv
   assign lfsr_unused_s = ^{lfsr_s[7:2], lfsr_s[0]};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      adv_s       = 1'b0;
      chk_s       = 1'b0;
      fin_s       = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load_s      = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_RUN: begin
            chk_s = vld_r[DUT_LAT-1];
            if (drv_idx_r == LAST_IDX) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               adv_s = 1'b1;
            end
         end
         ST_DRAIN: begin
            chk_s = vld_r[DUT_LAT-1];
            if (chk_s && (chk_idx_r == LAST_IDX)) begin
               fin_s       = 1'b1;
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // A vector fails on a wrong true output or a non-complementary pair, counted once
   assign fail_s    = chk_s & ((b_obs ^ dly_r[DUT_LAT-1]) | ~(b_obs ^ c_obs));
   assign err_nxt_s = (fail_s && (err_count_r != ERR_MAX)) ? (err_count_r + ERR_W'(1'b1))
                                                          : err_count_r;

   // Stimulus, delay line, indices and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_drv_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_count_r <= '0;
         first_err_r <= NO_ERR_IDX;
         drv_idx_r   <= 8'd0;
         chk_idx_r   <= 8'd0;
         dly_r       <= '0;
         vld_r       <= '0;
      end else if (load_s) begin
         a_drv_r     <= SEED_EFF[0];
         busy_r      <= 1'b1;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_count_r <= '0;
         first_err_r <= NO_ERR_IDX;
         drv_idx_r   <= 8'd0;
         chk_idx_r   <= 8'd0;
         dly_r       <= '0;
         vld_r       <= '0;
      end else begin
         if (adv_s) begin
            a_drv_r   <= lfsr_s[1];
            drv_idx_r <= drv_idx_r + 8'd1;
         end
         if (busy_r) begin
            dly_r <= DUT_LAT'({dly_r, a_drv_r});
            vld_r <= DUT_LAT'({vld_r, (state_r == ST_RUN)});
         end
         if (chk_s) begin
            chk_idx_r <= chk_idx_r + 8'd1;
         end
         err_count_r <= err_nxt_s;
         if (fail_s && (first_err_r == NO_ERR_IDX)) begin
            first_err_r <= chk_idx_r;
         end
         if (fin_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_nxt_s == '0);
         end
      end
   end

   assign a_drv         = a_drv_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign pass          = pass_r;
   assign err_count     = err_count_r;
   assign first_err_idx = first_err_r;

endmodule

// File: tb/tb_ff_bist_ctrl.sv
// Directed bench for ff_bist_ctrl: a behavioural flip-flop with selectable faults sits on a_drv,
// and run results, latency and the stimulus stream are compared against hand-computed values.
module tb_ff_bist_ctrl;

   // Stimulus bits k=0..15 for seed 8'hA5 (bit k at position k), worked out by hand
   localparam logic [15:0] STREAM = 16'h72A5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       b_obs;
   logic       c_obs;
   logic       a_drv, busy, done, pass;
   logic [7:0] err_count, first_err_idx;
   logic       a_drv3, busy3, done3, pass3;
   logic [2:0] err_count3;
   logic [7:0] first_err_idx3;

   logic       q = 1'b0;
   int         mode = 0;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_bad = 0;
   logic [15:0] stream_v;

   ff_bist_ctrl u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .a_drv         (a_drv),
      .b_obs         (b_obs),
      .c_obs         (c_obs),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx)
   );

   ff_bist_ctrl #(.ERR_W(3)) u_dut3 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .a_drv         (a_drv3),
      .b_obs         (b_obs),
      .c_obs         (c_obs),
      .busy          (busy3),
      .done          (done3),
      .pass          (pass3),
      .err_count     (err_count3),
      .first_err_idx (first_err_idx3)
   );

   always #5 clk = ~clk;

   // Flip-flop under test
   always @(posedge clk) q <= a_drv;

   // Fault modes: 0 good, 1 inverted, 2 complement stuck to true, 3 vector 5 corrupted
   always_comb begin
      b_obs = q;
      c_obs = ~q;
      case (mode)
         1: begin b_obs = ~q; c_obs = q; end
         2: begin b_obs = q;  c_obs = q; end
         3: begin b_obs = (cyc == 6) ? ~q : q; c_obs = ~b_obs; end
         default: begin b_obs = q; c_obs = ~q; end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Pulses start from #1 after an edge, follows the run to done and checks stream and latency
   task automatic do_run(input string tag, input int dup_at);
      int lat;
      lat = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      check({tag, ".e0_busy"}, busy, 1'b1);
      check({tag, ".e0_done"}, done, 1'b0);
      check({tag, ".e0_err"}, err_count, 8'd0);
      check({tag, ".e0_first"}, first_err_idx, 8'hFF);
      check({tag, ".bit0"}, a_drv, stream_v[0]);
      for (int j = 1; (j <= 40) && (lat == 0); j++) begin
         @(posedge clk); #1;
         cyc = j;
         start = (j == dup_at) ? 1'b1 : 1'b0;
         if (j < 16) begin
            check($sformatf("%s.bit%0d", tag, j), a_drv, stream_v[j]);
         end else if (j == 16) begin
            check({tag, ".hold"}, a_drv, stream_v[15]);
         end
         if (done) lat = j;
      end
      start = 1'b0;
      check({tag, ".latency"}, lat, 17);
      check({tag, ".busy_end"}, busy, 1'b0);
   endtask

   initial begin
      stream_v = STREAM;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.a_drv", a_drv, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
      check("rst.pass", pass, 1'b0);
      check("rst.err", err_count, 8'd0);
      check("rst.first", first_err_idx, 8'hFF);
      rst_n = 1'b1;
      @(posedge clk); #1;

      mode = 0;
      do_run("good", 0);
      check("good.pass", pass, 1'b1);
      check("good.err", err_count, 8'd0);
      check("good.first", first_err_idx, 8'hFF);

      // Observations outside a run must be ignored
      mode = 1;
      repeat (4) @(posedge clk);
      #1;
      check("idle.err", err_count, 8'd0);
      check("idle.pass", pass, 1'b1);
      check("idle.done", done, 1'b1);

      do_run("inv", 0);
      check("inv.err", err_count, 8'd16);
      check("inv.first", first_err_idx, 8'd0);
      check("inv.pass", pass, 1'b0);

      mode = 2;
      do_run("ctie", 0);
      check("ctie.err", err_count, 8'd16);
      check("ctie.first", first_err_idx, 8'd0);
      check("ctie.pass", pass, 1'b0);
      check("ctie.err_w3", err_count3, 3'd7);
      check("ctie.first_w3", first_err_idx3, 8'd0);
      check("ctie.done_w3", done3, 1'b1);

      mode = 3;
      do_run("v5", 0);
      check("v5.err", err_count, 8'd1);
      check("v5.first", first_err_idx, 8'd5);
      check("v5.pass", pass, 1'b0);
      check("v5.err_w3", err_count3, 3'd1);

      // Asynchronous reset in the middle of a failing run
      mode = 1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mid.err_before", err_count, 8'd5);
      check("mid.busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid.a_drv", a_drv, 1'b0);
      check("mid.busy", busy, 1'b0);
      check("mid.done", done, 1'b0);
      check("mid.pass", pass, 1'b0);
      check("mid.err", err_count, 8'd0);
      check("mid.first", first_err_idx, 8'hFF);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mode = 0;
      @(posedge clk); #1;
      do_run("post", 0);
      check("post.pass", pass, 1'b1);
      check("post.err", err_count, 8'd0);

      // Second start while busy is ignored; the following start in DONE restarts cleanly
      do_run("dup", 5);
      check("dup.pass", pass, 1'b1);
      check("dup.err", err_count, 8'd0);
      do_run("again", 0);
      check("again.pass", pass, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
